// File: rtl/fb_write_ctrl.sv
// Double-buffered framebuffer write controller: stores raster-order pixel results and swaps buffers at frame end.
// Define FB_VSYNC_SWAP_EN to hold the buffer swap until a vsync pulse (tear-free); otherwise the swap is immediate.
module fb_write_ctrl #(
    parameter int W      = 600,
    parameter int H      = 400,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [7:0]        pix_iter,
    output logic              pix_ready,
    input  logic              vsync,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_buf_sel,
    output logic              rd_buf_sel,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              accept;
    logic              clear;
    logic              swap;
    logic              swap_cond;
    logic              swap_q;
    logic              at_last;

`ifdef FB_VSYNC_SWAP_EN
    assign swap_cond = vsync;
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
    assign swap_cond    = 1'b1;
`endif

    assign at_last = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An abort in WRITE still lets a same-cycle pixel be written; it just restarts the counters.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        clear      = 1'b0;
        swap       = 1'b0;
        pix_ready  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = WRITE;
                    clear      = 1'b1;
                end
            end
            WRITE: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                accept    = pix_valid;
                if (frame_start) begin
                    clear = 1'b1;
                end else if (pix_valid && at_last) begin
                    state_next = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                busy = 1'b1;
                if (swap_cond) begin
                    swap       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The linear address runs alongside x/y; x/y only exist to spot the last pixel without a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else if (clear) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else if (accept) begin
            if (at_last) begin
                x_cnt    <= '0;
                y_cnt    <= '0;
                addr_cnt <= '0;
            end else if (x_cnt == X_LAST) begin
                x_cnt    <= '0;
                y_cnt    <= y_cnt + 1'b1;
                addr_cnt <= addr_cnt + 1'b1;
            end else begin
                x_cnt    <= x_cnt + 1'b1;
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= addr_cnt;
                wr_data <= pix_iter;
            end
        end
    end

    // frame_done trails the buffer toggle by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_buf_sel <= 1'b0;
            swap_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_buf_sel <= rd_buf_sel ^ swap;
            swap_q     <= swap;
            frame_done <= swap_q;
        end
    end

    assign wr_buf_sel = ~rd_buf_sel;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Self-checking bench for fb_write_ctrl (W=4, H=2): vector table, directed corner sequences and random traffic.
module tb_fb_write_ctrl;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              pix_valid = 1'b0;
    logic [7:0]        pix_iter = 8'h00;
    logic              vsync = 1'b0;
    logic              pix_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_buf_sel;
    logic              rd_buf_sel;
    logic              busy;
    logic              frame_done;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 collecting pixels, 2 waiting to swap; m_n counts pixels taken this frame.
    int       m_mode;
    int       m_n;
    logic     m_wen;
    int       m_waddr;
    int       m_wdata;
    logic     m_rd;
    logic     m_swapped;
    logic     m_done;

    typedef struct {
        logic       fs;
        logic       pv;
        logic [7:0] it;
        logic       vs;
        logic       e_wen;
        int         e_addr;
        int         e_data;
        logic       e_ready;
    } vec_t;

    vec_t vecs[10];

    fb_write_ctrl #(.W(W), .H(H), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_iter    (pix_iter),
        .pix_ready   (pix_ready),
        .vsync       (vsync),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_buf_sel  (wr_buf_sel),
        .rd_buf_sel  (rd_buf_sel),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_mode    = 0;
        m_n       = 0;
        m_wen     = 1'b0;
        m_waddr   = 0;
        m_wdata   = 0;
        m_rd      = 1'b0;
        m_swapped = 1'b0;
        m_done    = 1'b0;
    endtask

    task automatic modelEdge();
        logic swap_ok;
`ifdef FB_VSYNC_SWAP_EN
        swap_ok = vsync;
`else
        swap_ok = 1'b1;
`endif
        m_done    = m_swapped;
        m_swapped = 1'b0;
        m_wen     = 1'b0;
        case (m_mode)
            0: begin
                if (frame_start) begin
                    m_mode = 1;
                    m_n    = 0;
                end
            end
            1: begin
                if (pix_valid) begin
                    m_wen   = 1'b1;
                    m_waddr = m_n;
                    m_wdata = int'(pix_iter);
                end
                if (frame_start) begin
                    m_n = 0;
                end else if (pix_valid) begin
                    m_n++;
                    if (m_n == W * H) m_mode = 2;
                end
            end
            default: begin
                if (swap_ok) begin
                    m_rd      = !m_rd;
                    m_swapped = 1'b1;
                    m_mode    = 0;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input logic fs, input logic pv, input logic [7:0] it, input logic vs);
        frame_start = fs;
        pix_valid   = pv;
        pix_iter    = it;
        vsync       = vs;
        @(posedge clk);
        modelEdge();
        #1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        vsync       = 1'b0;
    endtask

    task automatic checkOutput();
        check1("pix_ready",  int'(pix_ready),  int'(m_mode == 1));
        check1("busy",       int'(busy),       int'(m_mode != 0));
        check1("wr_en",      int'(wr_en),      int'(m_wen));
        check1("wr_addr",    int'(wr_addr),    m_waddr);
        check1("wr_data",    int'(wr_data),    m_wdata);
        check1("rd_buf_sel", int'(rd_buf_sel), int'(m_rd));
        check1("wr_buf_sel", int'(wr_buf_sel), int'(!m_rd));
        check1("frame_done", int'(frame_done), int'(m_done));
    endtask

    task automatic checkResetValues(input string tag);
        check1({tag, "_wr_en"},      int'(wr_en),      0);
        check1({tag, "_wr_addr"},    int'(wr_addr),    0);
        check1({tag, "_wr_data"},    int'(wr_data),    0);
        check1({tag, "_rd_buf_sel"}, int'(rd_buf_sel), 0);
        check1({tag, "_wr_buf_sel"}, int'(wr_buf_sel), 1);
        check1({tag, "_busy"},       int'(busy),       0);
        check1({tag, "_frame_done"}, int'(frame_done), 0);
        check1({tag, "_pix_ready"},  int'(pix_ready),  0);
    endtask

    initial begin
        int seen;
        int exp_lat;
        logic rd_before;
        logic vs;

        // One frame of W*H pixels with iter=i, written one cycle after each acceptance.
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            vecs[i + 1] = '{1'b0, 1'b1, 8'(i), 1'b0, 1'b1, i, i, (i != 7)};
        end
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 7, 7, 1'b0};

        modelReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].fs, vecs[i].pv, vecs[i].it, vecs[i].vs);
            check1($sformatf("tbl%0d_wr_en", i),     int'(wr_en),     int'(vecs[i].e_wen));
            check1($sformatf("tbl%0d_wr_addr", i),   int'(wr_addr),   vecs[i].e_addr);
            check1($sformatf("tbl%0d_wr_data", i),   int'(wr_data),   vecs[i].e_data);
            check1($sformatf("tbl%0d_pix_ready", i), int'(pix_ready), int'(vecs[i].e_ready));
            checkOutput();
        end

`ifdef FB_VSYNC_SWAP_EN
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput();
`endif
        repeat (2) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            checkOutput();
        end

        // Swap latency, with vsync coincident with the last acceptance.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i * 17 + 3), 1'b0);
            checkOutput();
        end
        applyStimulus(1'b0, 1'b1, 8'hF0, 1'b1);
        checkOutput();
        rd_before = rd_buf_sel;
        seen = 0;
        for (int k = 1; k <= 14; k++) begin
            vs = (k == 10);
            applyStimulus(1'b0, 1'b0, 8'h00, vs);
            checkOutput();
            if (seen == 0 && rd_buf_sel != rd_before) seen = k;
        end
`ifdef FB_VSYNC_SWAP_EN
        exp_lat = 10;
`else
        exp_lat = 1;
`endif
        check1("swap_latency", seen, exp_lat);

        // Abort after 3 pixels, toggling pix_valid, then frame_start during the swap wait.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(40 + i), 1'b0);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
        checkOutput();
        check1("restart_addr", int'(wr_addr), 0);
        check1("restart_data", int'(wr_data), 8'hAA);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, (i % 2 == 0), 8'(i + 100), 1'b0);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput();
        check1("fs_in_wait_ready", int'(pix_ready), 0);
`ifdef FB_VSYNC_SWAP_EN
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput();
`endif
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            checkOutput();
        end

        // Asynchronous reset in the middle of a frame.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i + 60), 1'b0);
            checkOutput();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async");
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
        checkOutput();
        check1("post_reset_addr", int'(wr_addr), 0);
        check1("post_reset_data", int'(wr_data), 8'h5A);
        check1("post_reset_wbuf", int'(wr_buf_sel), 1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
            checkOutput();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
